// File: rtl/tenthirty_gen.sv
// Ten-and-a-half card game controller: deals from an external card LUT,
// scores player and dealer hands in half-points and keeps a session tally.
//
// Card handshake: card_req acts as ready and card_valid as valid. A card
// transfers on a clk edge where both are high and card_value is 1..13.
// Values outside 1..13 are dropped with card_req left high. card_valid is
// ignored whenever card_req is low. card_req always falls on the edge that
// accepts a card, so at most one card moves per request.
module tenthirty_gen #(
  parameter int ROUNDS        = 4,
  parameter int MAX_CARDS     = 5,
  parameter int AUTO_DEALER   = 1,
  parameter int DEALER_STAND  = 14,
  parameter int FIVE_CARD_WIN = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_hit,
  input  logic       btn_stand,
  output logic       card_req,
  input  logic       card_valid,
  input  logic [3:0] card_value,
  output logic [5:0] player_pts,
  output logic [5:0] dealer_pts,
  output logic [2:0] player_cnt,
  output logic [2:0] dealer_cnt,
  output logic [3:0] last_card,
  output logic [2:0] state,
  output logic [3:0] round,
  output logic [3:0] player_wins,
  output logic [3:0] dealer_wins,
  output logic [2:0] led
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_DEAL    = 3'd1,
    S_PLAYER  = 3'd2,
    S_DEALER  = 3'd3,
    S_COMPARE = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  localparam logic [2:0] MAX_C    = 3'(MAX_CARDS);
  localparam logic [5:0] STAND_C  = 6'(DEALER_STAND);
  localparam logic [3:0] ROUNDS_C = 4'(ROUNDS);
  localparam logic [5:0] LIMIT    = 6'd21;

  state_t     state_q;
  logic       hit_q, stand_q;
  logic       hit_p, stand_p;
  logic       accept;
  logic       to_player;
  logic [5:0] card_pts;
  logic       p_bust, d_bust, p_five, d_five;
  logic       player_takes;
  logic       enter_cmp;

  assign state = state_q;

  // Button edges, card scoring, hand routing and the game verdict.
  always_comb begin
    hit_p     = btn_hit & ~hit_q;
    stand_p   = btn_stand & ~stand_q;
    accept    = card_req && card_valid && (card_value != 4'd0) && (card_value <= 4'd13);
    card_pts  = (card_value >= 4'd11) ? 6'd1 : {1'b0, card_value, 1'b0};
    // During the deal the first card goes to the player, the second to the dealer.
    to_player = (state_q == S_PLAYER) || ((state_q == S_DEAL) && (player_cnt == 3'd0));
    p_bust    = player_pts > LIMIT;
    d_bust    = dealer_pts > LIMIT;
    p_five    = (FIVE_CARD_WIN != 0) && (player_cnt == MAX_C) && !p_bust;
    d_five    = (FIVE_CARD_WIN != 0) && (dealer_cnt == MAX_C) && !d_bust;
    if (p_bust)
      player_takes = 1'b0;
    else if (d_bust)
      player_takes = 1'b1;
    else if (p_five != d_five)
      player_takes = p_five;
    else
      player_takes = player_pts > dealer_pts;
    // The dealer turn ends only while no card is outstanding.
    enter_cmp = 1'b0;
    if ((state_q == S_DEALER) && !card_req) begin
      if (p_bust)
        enter_cmp = 1'b1;
      else if (AUTO_DEALER != 0)
        enter_cmp = !((dealer_pts < STAND_C) && (dealer_cnt < MAX_C) && (dealer_pts <= LIMIT));
      else
        enter_cmp = (dealer_pts >= LIMIT) || (dealer_cnt == MAX_C) || stand_p;
    end
  end

  // Game sequencing, card bookkeeping and session scoring.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      card_req    <= 1'b0;
      player_pts  <= 6'd0;
      dealer_pts  <= 6'd0;
      player_cnt  <= 3'd0;
      dealer_cnt  <= 3'd0;
      last_card   <= 4'd0;
      round       <= 4'd0;
      player_wins <= 4'd0;
      dealer_wins <= 4'd0;
      led         <= 3'b000;
      hit_q       <= 1'b0;
      stand_q     <= 1'b0;
    end else begin
      hit_q   <= btn_hit;
      stand_q <= btn_stand;
      if (accept) begin
        card_req  <= 1'b0;
        last_card <= card_value;
        if (to_player) begin
          player_pts <= player_pts + card_pts;
          if (player_cnt != MAX_C) player_cnt <= player_cnt + 3'd1;
        end else begin
          dealer_pts <= dealer_pts + card_pts;
          if (dealer_cnt != MAX_C) dealer_cnt <= dealer_cnt + 3'd1;
        end
      end
      case (state_q)
        S_IDLE: begin
          if (hit_p) begin
            player_pts <= 6'd0;
            dealer_pts <= 6'd0;
            player_cnt <= 3'd0;
            dealer_cnt <= 3'd0;
            round      <= round + 4'd1;
            card_req   <= 1'b1;
            state_q    <= S_DEAL;
          end
        end
        S_DEAL: begin
          if (accept) begin
            if (!to_player) state_q <= S_PLAYER;
          end else if (!card_req) begin
            card_req <= 1'b1;
          end
        end
        S_PLAYER: begin
          // Auto-exit wins over buttons; stand wins over a simultaneous hit.
          if (!card_req) begin
            if ((player_pts >= LIMIT) || (player_cnt == MAX_C))
              state_q <= S_DEALER;
            else if (stand_p)
              state_q <= S_DEALER;
            else if (hit_p)
              card_req <= 1'b1;
          end
        end
        S_DEALER: begin
          if (enter_cmp) begin
            state_q <= S_COMPARE;
            led     <= {1'b0, !player_takes, player_takes};
            if (player_takes) begin
              if (player_wins != 4'd15) player_wins <= player_wins + 4'd1;
            end else begin
              if (dealer_wins != 4'd15) dealer_wins <= dealer_wins + 4'd1;
            end
          end else if (!card_req) begin
            if (AUTO_DEALER != 0)
              card_req <= 1'b1;
            else if (hit_p)
              card_req <= 1'b1;
          end
        end
        S_COMPARE: begin
          if (stand_p) begin
            if (round < ROUNDS_C) begin
              state_q <= S_IDLE;
              led     <= 3'b000;
            end else begin
              state_q <= S_DONE;
              led     <= 3'b100;
            end
          end
        end
        S_DONE: begin
          state_q <= S_DONE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tenthirty_gen.sv
// Bench for tenthirty_gen: randomized games plus directed hands, with a
// hand-level model (card lists per side) checked on every clock.
module tb_tenthirty_gen;

  localparam int ROUNDS = 2;
  localparam int MAXC   = 5;
  localparam logic [2:0] S_IDLE = 3'd0, S_DEAL = 3'd1, S_PLAYER = 3'd2,
                         S_DEALER = 3'd3, S_COMPARE = 3'd4, S_DONE = 3'd5;

  // clock / reset and stimulus signals
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_hit = 1'b0, btn_stand = 1'b0;
  logic       card_valid = 1'b0;
  logic [3:0] card_value = 4'd0;

  logic       card_req, nf_card_req;
  logic [5:0] player_pts, dealer_pts, nf_player_pts, nf_dealer_pts;
  logic [2:0] player_cnt, dealer_cnt, nf_player_cnt, nf_dealer_cnt;
  logic [3:0] last_card, nf_last_card, round, nf_round;
  logic [3:0] player_wins, dealer_wins, nf_player_wins, nf_dealer_wins;
  logic [2:0] state, nf_state, led, nf_led;

  always #5 clk = ~clk;

  tenthirty_gen #(.ROUNDS(ROUNDS), .MAX_CARDS(MAXC), .AUTO_DEALER(1),
                  .DEALER_STAND(14), .FIVE_CARD_WIN(1)) u_dut (
    .clk(clk), .rst(rst), .btn_hit(btn_hit), .btn_stand(btn_stand),
    .card_req(card_req), .card_valid(card_valid), .card_value(card_value),
    .player_pts(player_pts), .dealer_pts(dealer_pts),
    .player_cnt(player_cnt), .dealer_cnt(dealer_cnt),
    .last_card(last_card), .state(state), .round(round),
    .player_wins(player_wins), .dealer_wins(dealer_wins), .led(led)
  );

  // Same stimulus, five-card rule disabled: only the verdict may differ.
  tenthirty_gen #(.ROUNDS(ROUNDS), .MAX_CARDS(MAXC), .AUTO_DEALER(1),
                  .DEALER_STAND(14), .FIVE_CARD_WIN(0)) u_nf (
    .clk(clk), .rst(rst), .btn_hit(btn_hit), .btn_stand(btn_stand),
    .card_req(nf_card_req), .card_valid(card_valid), .card_value(card_value),
    .player_pts(nf_player_pts), .dealer_pts(nf_dealer_pts),
    .player_cnt(nf_player_cnt), .dealer_cnt(nf_dealer_cnt),
    .last_card(nf_last_card), .state(nf_state), .round(nf_round),
    .player_wins(nf_player_wins), .dealer_wins(nf_dealer_wins), .led(nf_led)
  );

  int checks = 0;
  int errors = 0;

  // model: cards held by each side, plus session tallies
  logic [3:0] p_hand[$];
  logic [3:0] d_hand[$];
  logic [3:0] deck[$];
  bit         moves[$];
  logic [3:0] exp_last;
  int         exp_round, exp_pw, exp_dw, exp_pw_nf, exp_dw_nf;
  bit         exp_ptake, exp_ptake_nf, scored, check_en, junk_once;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int pts_of(input logic [3:0] v);
    return (v >= 4'd11) ? 1 : 2 * int'(v);
  endfunction

  function automatic int hand_sum(input bit player);
    int s = 0;
    if (player) foreach (p_hand[i]) s += pts_of(p_hand[i]);
    else        foreach (d_hand[i]) s += pts_of(d_hand[i]);
    return s;
  endfunction

  function automatic bit player_takes(input bit five);
    int ps = hand_sum(1'b1);
    int ds = hand_sum(1'b0);
    bit p5, d5;
    if (ps > 21) return 1'b0;
    if (ds > 21) return 1'b1;
    p5 = five && (p_hand.size() == MAXC);
    d5 = five && (d_hand.size() == MAXC);
    if (p5 != d5) return p5;
    return ps > ds;
  endfunction

  function automatic bit should_draw();
    return (hand_sum(1'b1) <= 21) && (hand_sum(1'b0) < 14) && (d_hand.size() < MAXC);
  endfunction

  function automatic logic [3:0] next_card();
    if (deck.size() > 0) return deck.pop_front();
    return 4'($urandom_range(1, 13));
  endfunction

  task automatic model_clear();
    p_hand.delete();
    d_hand.delete();
    exp_last  = 4'd0;
    exp_round = 0;
    exp_pw    = 0; exp_dw    = 0;
    exp_pw_nf = 0; exp_dw_nf = 0;
    scored    = 1'b0;
  endtask

  // compare process: outputs against the model, #1 after every edge
  always @(posedge clk) begin
    #1;
    if (check_en) begin
      if ((state == S_COMPARE) && !scored) begin
        exp_ptake    = player_takes(1'b1);
        exp_ptake_nf = player_takes(1'b0);
        if (exp_ptake) begin if (exp_pw < 15) exp_pw++; end
        else begin if (exp_dw < 15) exp_dw++; end
        if (exp_ptake_nf) begin if (exp_pw_nf < 15) exp_pw_nf++; end
        else begin if (exp_dw_nf < 15) exp_dw_nf++; end
        scored = 1'b1;
      end
      chk("player_pts", player_pts, hand_sum(1'b1));
      chk("dealer_pts", dealer_pts, hand_sum(1'b0));
      chk("player_cnt", player_cnt, p_hand.size());
      chk("dealer_cnt", dealer_cnt, d_hand.size());
      chk("last_card", last_card, exp_last);
      chk("round", round, exp_round);
      chk("player_wins", player_wins, exp_pw);
      chk("dealer_wins", dealer_wins, exp_dw);
      chk("nf_player_pts", nf_player_pts, hand_sum(1'b1));
      chk("nf_dealer_cnt", nf_dealer_cnt, d_hand.size());
      chk("nf_round", nf_round, exp_round);
      chk("nf_player_wins", nf_player_wins, exp_pw_nf);
      chk("nf_dealer_wins", nf_dealer_wins, exp_dw_nf);
      if (state == S_COMPARE) begin
        chk("led_compare", led, {1'b0, !exp_ptake, exp_ptake});
        chk("nf_led_compare", nf_led, {1'b0, !exp_ptake_nf, exp_ptake_nf});
      end else if (state == S_DONE) begin
        chk("led_done", led, 3'b100);
      end else begin
        chk("led_idle", led, 3'b000);
      end
    end
  end

  // driver tasks: all entered and left on a falling edge
  task automatic step();
    @(negedge clk);
    card_valid = 1'b0;
    if ((card_req === 1'b0) && ($urandom_range(0, 3) == 0)) begin
      card_valid = 1'b1;
      card_value = 4'($urandom_range(0, 15));
    end
  endtask

  task automatic press(input bit hit);
    if (hit) btn_hit = 1'b1; else btn_stand = 1'b1;
    step();
    btn_hit   = 1'b0;
    btn_stand = 1'b0;
    step();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    btn_hit = 1'b0; btn_stand = 1'b0; card_valid = 1'b0;
    model_clear();
    step();
    step();
    rst = 1'b0;
    check_en = 1'b1;
  endtask

  task automatic get_card(input bit to_p);
    int n = 0;
    logic [3:0] v;
    while ((card_req !== 1'b1) && (n < 30)) begin step(); n++; end
    if (card_req !== 1'b1) begin
      chk("card_req_wait", card_req, 1);
      return;
    end
    if (junk_once) begin
      junk_once  = 1'b0;
      card_valid = 1'b1;
      card_value = 4'd0;
      @(negedge clk);
      chk("junk0_req_held", card_req, 1);
      card_value = 4'd14;
      @(negedge clk);
      chk("junk14_req_held", card_req, 1);
    end
    v = next_card();
    card_valid = 1'b1;
    card_value = v;
    if (to_p) p_hand.push_back(v); else d_hand.push_back(v);
    exp_last = v;
    @(negedge clk);
    card_valid = 1'b0;
    chk("req_drop", card_req, 0);
    chk("nf_req_drop", nf_card_req, 0);
  endtask

  task automatic start_game();
    chk("idle_state", state, S_IDLE);
    if ($urandom_range(0, 1) == 1) begin
      press(1'b0);
      chk("idle_stand_ignored", state, S_IDLE);
    end
    p_hand.delete();
    d_hand.delete();
    exp_round++;
    scored = 1'b0;
    press(1'b1);
  endtask

  task automatic deal();
    get_card(1'b1);
    get_card(1'b0);
    chk("deal_to_player", state, S_PLAYER);
  endtask

  task automatic player_phase();
    for (int k = 0; k < 10; k++) begin
      int ps = hand_sum(1'b1);
      bit do_hit;
      if ((ps >= 21) || (p_hand.size() >= MAXC)) return;
      chk("player_state", state, S_PLAYER);
      if (moves.size() > 0) do_hit = moves.pop_front();
      else if (ps < 14)     do_hit = ($urandom_range(0, 3) != 0);
      else                  do_hit = ($urandom_range(0, 3) == 0);
      if (do_hit) begin
        press(1'b1);
        get_card(1'b1);
      end else begin
        press(1'b0);
        return;
      end
    end
  endtask

  task automatic dealer_phase();
    bit done = 1'b0;
    for (int k = 0; (k < 60) && !done; k++) begin
      if (card_req === 1'b1) begin
        chk("dealer_draw_wanted", card_req, should_draw());
        get_card(1'b0);
      end else if (state == S_COMPARE) begin
        chk("dealer_stop_wanted", card_req, should_draw());
        done = 1'b1;
      end else begin
        step();
      end
    end
    if (!done) chk("compare_reached", state, S_COMPARE);
  endtask

  task automatic compare_phase();
    logic [2:0] nxt;
    if ($urandom_range(0, 1) == 1) begin
      press(1'b1);
      chk("cmp_hit_ignored", state, S_COMPARE);
    end
    repeat ($urandom_range(0, 3)) step();
    press(1'b0);
    nxt = (exp_round < ROUNDS) ? S_IDLE : S_DONE;
    chk("after_cmp_state", state, nxt);
    chk("nf_after_cmp_state", nf_state, nxt);
  endtask

  task automatic play_game();
    start_game();
    deal();
    player_phase();
    dealer_phase();
    compare_phase();
  endtask

  // main sequence: directed hands first, then random sessions
  initial begin
    do_reset();
    chk("reset_state", state, S_IDLE);
    chk("reset_req", card_req, 0);
    chk("reset_led", led, 3'b000);

    // stand on 20; dealer 13 then two fives reaches 21
    deck = {4'd10, 4'd13, 4'd5, 4'd5};
    moves = {1'b0};
    start_game(); deal(); player_phase(); dealer_phase();
    chk("r028_player_pts", player_pts, 20);
    chk("r028_dealer_pts", dealer_pts, 21);
    chk("r028_led", led, 3'b010);
    chk("r028_dealer_wins", dealer_wins, 1);
    compare_phase();

    // player busts at 22, dealer never draws
    deck = {4'd12, 4'd3, 4'd13, 4'd10};
    moves = {1'b1, 1'b1};
    start_game(); deal(); player_phase(); dealer_phase();
    chk("r029_player_pts", player_pts, 22);
    chk("r029_dealer_pts", dealer_pts, 6);
    chk("r029_dealer_cnt", dealer_cnt, 1);
    chk("r029_dealer_wins", dealer_wins, 2);
    compare_phase();

    // session exhausted: DONE holds and ignores hit
    chk("r032_state", state, S_DONE);
    chk("r032_led", led, 3'b100);
    press(1'b1);
    chk("r032_hit_ignored", state, S_DONE);
    chk("r032_round", round, 2);

    // five-card 9 half-points against dealer 20
    do_reset();
    deck = {4'd1, 4'd10, 4'd1, 4'd1, 4'd1, 4'd11};
    moves = {1'b1, 1'b1, 1'b1, 1'b1};
    start_game(); deal(); player_phase(); dealer_phase();
    chk("r030_player_pts", player_pts, 9);
    chk("r030_player_cnt", player_cnt, 5);
    chk("r030_led_five", led, 3'b001);
    chk("r030_player_wins", player_wins, 1);
    chk("r030_nf_led", nf_led, 3'b010);
    chk("r030_nf_dealer_wins", nf_dealer_wins, 1);
    compare_phase();

    // out-of-range values on the bus are dropped, 7 is taken
    deck = {4'd7, 4'd4};
    junk_once = 1'b1;
    start_game(); deal();
    chk("r031_player_pts", player_pts, 14);
    chk("r031_dealer_pts", dealer_pts, 8);
    chk("r031_last_card", last_card, 4);
    player_phase(); dealer_phase(); compare_phase();

    // reset lands on the same edge as a card acceptance
    do_reset();
    start_game(); deal();
    press(1'b1);
    chk("r033_req_up", card_req, 1);
    card_valid = 1'b1;
    card_value = 4'd9;
    rst = 1'b1;
    model_clear();
    step();
    rst = 1'b0;
    chk("r033_state", state, S_IDLE);
    chk("r033_player_pts", player_pts, 0);
    chk("r033_player_cnt", player_cnt, 0);
    chk("r033_dealer_pts", dealer_pts, 0);
    chk("r033_round", round, 0);
    chk("r033_last_card", last_card, 0);
    chk("r033_req", card_req, 0);
    chk("r033_led", led, 3'b000);

    // random sessions
    for (int s = 0; s < 25; s++) begin
      do_reset();
      for (int g = 0; g < ROUNDS; g++) play_game();
      press(1'b1);
      chk("session_done", state, S_DONE);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule

// File: doc/tenthirty_gen.md
TENTHIRTY_GEN -- requirements
Module: tenthirty_gen

Interface
REQ-001 Parameter ROUNDS, default 4: games per session; legal range 1..15.
REQ-002 Parameter MAX_CARDS, default 5: card limit per hand; legal range 2..7.
REQ-003 Parameter AUTO_DEALER, default 1: 1 = dealer draws automatically, 0 = dealer is driven by the buttons like the player.
REQ-004 Parameter DEALER_STAND, default 14: in auto mode the dealer draws while its total is below this many half-points (14 = 7.0).
REQ-005 Parameter FIVE_CARD_WIN, default 1: a non-bust hand of MAX_CARDS cards beats any hand that is not also such a hand.
REQ-006 Ports, one per line:
- clk  in  1  sole clock.
- rst  in  1  reset; synchronous, active-high.
- btn_hit  in  1  draw / start, level input.
- btn_stand  in  1  stand / advance, level input.
- card_req  out  1  request one card from the dealer LUT.
- card_valid  in  1  card_value is valid this cycle.
- card_value  in  4  card face value, 1..13.
- player_pts  out  6  player total in half-points.
- dealer_pts  out  6  dealer total in half-points.
- player_cnt  out  3  number of player cards.
- dealer_cnt  out  3  number of dealer cards.
- last_card  out  4  value of the last card accepted.
- state  out  3  IDLE=0, DEAL=1, PLAYER=2, DEALER=3, COMPARE=4, DONE=5.
- round  out  4  number of games started.
- player_wins  out  4  session win count, player.
- dealer_wins  out  4  session win count, dealer.
- led  out  3  [0] player won, [1] dealer won, [2] session done.

Function
REQ-007 Each button is registered once; its pulse is btn AND NOT btn_q, and the pulse acts in the same cycle it is seen.
REQ-008 Card points: 1..10 score 2*value half-points; 11..13 score 1 half-point.
REQ-009 Handshake: a card is accepted in a cycle where card_req=1 and card_valid=1.
REQ-010 After an acceptance, card_req SHALL be 0 in the next cycle; totals, counts and last_card update at that same edge.
REQ-011 card_valid with card_value 0 or >13 SHALL be discarded while card_req stays 1.
REQ-012 card_valid while card_req=0 SHALL be ignored.
REQ-013 IDLE: a hit pulse SHALL clear both hands, increment round, and enter DEAL; the stand button is ignored.
REQ-014 DEAL: request one card for the player, then one for the dealer; enter PLAYER in the cycle after the second acceptance.
REQ-015 PLAYER: a hit pulse while no request is outstanding SHALL raise card_req; button pulses while a request is outstanding are ignored.
REQ-016 PLAYER: a stand pulse with no request outstanding SHALL enter DEALER.
REQ-017 PLAYER SHALL auto-exit to DEALER one cycle after a card update that leaves player_pts>=21 or player_cnt=MAX_CARDS.
REQ-018 DEALER: entered with player_pts>21, go directly to COMPARE with no draw.
REQ-019 DEALER with AUTO_DEALER=1: request while dealer_pts<DEALER_STAND and dealer_cnt<MAX_CARDS and dealer_pts<=21; otherwise enter COMPARE; buttons are ignored.
REQ-020 DEALER with AUTO_DEALER=0: same rules as PLAYER (REQ-015..017), but the exit goes to COMPARE.
REQ-021 COMPARE, resolved on the entry cycle, first matching rule wins:
- player bust (>21): dealer wins.
- dealer bust: player wins.
- FIVE_CARD_WIN rule applies to exactly one side: that side wins.
- otherwise the higher total wins; a tie goes to the dealer.
REQ-022 COMPARE: led[1:0] SHALL be set one-hot per the result; exactly one win counter increments, once per game, saturating at 15.
REQ-023 COMPARE: a stand pulse SHALL go to IDLE when round<ROUNDS, else to DONE; led[1:0] clears on leaving COMPARE.
REQ-024 DONE: led=3'b100 and all counters held until rst; all buttons are ignored.
REQ-025 Width rules: totals cannot exceed 41; 6-bit arithmetic with no wrap; counts saturate at MAX_CARDS.

Reset
REQ-026 When rst=1 at a clk edge, all of the following SHALL be 0 from the next edge: state (IDLE), card_req, both totals, both counts, last_card, round, both win counters, led, button registers.
REQ-027 rst SHALL take priority over every event in the same cycle, including a card acceptance; a mid-game reset abandons the hand with no counter update.

Verification
REQ-028 Deal P=10, D=13; stand; auto dealer draws 5 (dealer 11 -> 21) -> COMPARE, player_pts=20, dealer_pts=21, dealer wins, led=010.
REQ-029 Deal P=12, D=3; hit 13 -> player_pts=2; hit 10 -> player_pts=22, auto-exit; dealer draws nothing -> dealer wins, dealer_wins=1.
REQ-030 Five-card hand P=1,1,1,1,11 (9 half-points) vs dealer at 20 -> player wins with FIVE_CARD_WIN=1; dealer wins with FIVE_CARD_WIN=0.
REQ-031 card_valid with card_value 0, then 14, then 7 -> only 7 accepted; card_req stays 1 until the 7, then 0 on the next cycle.
REQ-032 ROUNDS=2: play two games -> second stand in COMPARE enters DONE, led=100; a further hit pulse has no effect.
REQ-033 rst pulsed in PLAYER concurrent with card acceptance -> every output 0, round=0, card not counted.
